// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard controller.
// Forward-select codes, mult/div state enum, scoreboard entry layout,
// default mult/div latencies and a saturating tnew decrement helper.
package hazard_pkg;

   // Forward-select encodings driven on fwd_sel per source
   localparam logic [1:0] FWD_NONE = 2'd0;
   localparam logic [1:0] FWD_E    = 2'd1;
   localparam logic [1:0] FWD_M    = 2'd2;
   localparam logic [1:0] FWD_W    = 2'd3;

   // Default mult/div occupancy in cycles
   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 10;

   // Scoreboard tnew storage width; the TW parameter must not exceed it
   localparam int TNEW_MAX_W = 8;
   localparam logic [TNEW_MAX_W-1:0] TNEW_ZERO = 8'd0;
   localparam logic [TNEW_MAX_W-1:0] TNEW_ONE  = 8'd1;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   typedef struct packed {
      logic [4:0]            wa;
      logic [TNEW_MAX_W-1:0] tnew;
   } sb_entry_t;

   localparam sb_entry_t SB_EMPTY = '{wa: 5'd0, tnew: 8'd0};

   // Decrement a tnew value, holding at zero once the result exists
   function automatic logic [TNEW_MAX_W-1:0] tnew_dec(input logic [TNEW_MAX_W-1:0] t);
      logic [TNEW_MAX_W-1:0] r;
      if (t == TNEW_ZERO) r = TNEW_ZERO;
      else                r = t - TNEW_ONE;
      return r;
   endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// md_busy_cnt: mult/div occupancy tracker. A start seen from the E stage
// loads the latency counter; busy stays high for that many cycles.
// Only instantiated when HAZARD_MD_EN is defined.
module md_busy_cnt
   import hazard_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic is_div,
   output logic busy
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_LAT);
   localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_LAT);

   md_state_t        state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;

   // State and counter registers; reset aborts any count in progress
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= MD_IDLE;
         cnt_r   <= CNT_ZERO;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Next state: load latency on start, count down, leave BUSY on the last cycle
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         MD_IDLE: begin
            if (start) begin
               state_s = MD_BUSY;
               cnt_s   = is_div ? CNT_DIV : CNT_MULT;
            end else begin
               state_s = MD_IDLE;
               cnt_s   = CNT_ZERO;
            end
         end
         MD_BUSY: begin
            if (cnt_r <= CNT_ONE) begin
               state_s = MD_IDLE;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = MD_BUSY;
               cnt_s   = cnt_r - CNT_ONE;
            end
         end
         default: begin
            state_s = MD_IDLE;
            cnt_s   = CNT_ZERO;
         end
      endcase
   end

   assign busy = (state_r == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard detection and forward selection.
// Tracks E/M/W destination writes with their remaining result latency,
// stalls D when a source is needed before it exists, and picks the
// nearest forwarding stage. Define HAZARD_MD_EN to add mult/div HI/LO
// occupancy interlocking (md_busy_cnt).
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int NUM_SRC  = 2,
   parameter int TW       = 2,
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_SRC*5-1:0]  D_src_addr,
   input  logic [NUM_SRC-1:0]    D_src_used,
   input  logic [NUM_SRC*TW-1:0] D_tuse,
   input  logic [4:0]            D_wa,
   input  logic [TW-1:0]         D_tnew,
   input  logic                  D_md_start,
   input  logic                  D_md_is_div,
   input  logic                  D_md_use,
   output logic                  stall,
   output logic [NUM_SRC*2-1:0]  fwd_sel,
   output logic                  md_busy
);

   localparam logic [1:0] FWD_CODE [3] = '{FWD_E, FWD_M, FWD_W};

   sb_entry_t                 sb_e_r, sb_m_r, sb_w_r;
   sb_entry_t                 stage_s [3];
   sb_entry_t                 d_ent_s;
   logic                      hz_stall_s;
   logic                      md_stall_s;
   logic                      md_busy_s;
   logic                      stall_s;
   logic [NUM_SRC*2-1:0]      fwd_s;
   logic [4:0]                src_addr_s;
   logic [TNEW_MAX_W-1:0]     tuse_s;
   logic                      near_s;

   // Stage 0 is the nearest (youngest) producer
   assign stage_s[0] = sb_e_r;
   assign stage_s[1] = sb_m_r;
   assign stage_s[2] = sb_w_r;

   // Register hazards and nearest-stage forward selection for every source
   always_comb begin
      hz_stall_s = 1'b0;
      fwd_s      = {(NUM_SRC*2){1'b0}};
      src_addr_s = 5'd0;
      tuse_s     = TNEW_ZERO;
      near_s     = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src_addr_s = D_src_addr[i*5 +: 5];
         tuse_s     = TNEW_MAX_W'(D_tuse[i*TW +: TW]);
         near_s     = 1'b0;
         for (int s = 0; s < 3; s++) begin
            if (D_src_used[i] && (src_addr_s != 5'd0) && (src_addr_s == stage_s[s].wa)) begin
               if (tuse_s < stage_s[s].tnew) hz_stall_s = 1'b1;
               else                          hz_stall_s = hz_stall_s;
               if (!near_s) begin
                  near_s = 1'b1;
                  if (stage_s[s].tnew == TNEW_ZERO) fwd_s[i*2 +: 2] = FWD_CODE[s];
                  else                              fwd_s[i*2 +: 2] = FWD_NONE;
               end else begin
                  near_s = near_s;
               end
            end else begin
               hz_stall_s = hz_stall_s;
            end
         end
      end
   end

   assign stall_s = hz_stall_s | md_stall_s;

   // Entry presented to E: the D instruction, or a bubble while stalled
   always_comb begin
      if (stall_s) begin
         d_ent_s = SB_EMPTY;
      end else begin
         d_ent_s.wa   = D_wa;
         d_ent_s.tnew = TNEW_MAX_W'(D_tnew);
      end
   end

   // Scoreboard shift E->M->W with saturating tnew countdown
   always_ff @(posedge clk) begin
      if (reset) begin
         sb_e_r <= SB_EMPTY;
         sb_m_r <= SB_EMPTY;
         sb_w_r <= SB_EMPTY;
      end else begin
         sb_e_r      <= d_ent_s;
         sb_m_r.wa   <= sb_e_r.wa;
         sb_m_r.tnew <= tnew_dec(sb_e_r.tnew);
         sb_w_r.wa   <= sb_m_r.wa;
         sb_w_r.tnew <= tnew_dec(sb_m_r.tnew);
      end
   end

`ifdef HAZARD_MD_EN
   logic e_md_start_r;
   logic e_md_div_r;

   // Track a mult/div start sitting in E; a stalled start never enters
   always_ff @(posedge clk) begin
      if (reset) begin
         e_md_start_r <= 1'b0;
         e_md_div_r   <= 1'b0;
      end else begin
         e_md_start_r <= D_md_start & ~stall_s;
         e_md_div_r   <= D_md_start & D_md_is_div & ~stall_s;
      end
   end

   md_busy_cnt #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT)
   ) u_md_busy_cnt (
      .clk    (clk),
      .reset  (reset),
      .start  (e_md_start_r),
      .is_div (e_md_div_r),
      .busy   (md_busy_s)
   );

   // HI/LO users and new starts wait while the unit is or is about to be busy
   assign md_stall_s = (D_md_use | D_md_start) & (md_busy_s | e_md_start_r);
`else
   logic unused_md_s;
   localparam int unused_lat = MULT_LAT + DIV_LAT;

   assign unused_md_s = ^{D_md_start, D_md_is_div, D_md_use};
   assign md_stall_s  = 1'b0;
   assign md_busy_s   = 1'b0;
`endif

   assign stall   = reset ? 1'b0 : stall_s;
   assign fwd_sel = reset ? {(NUM_SRC*2){1'b0}} : fwd_s;
   assign md_busy = reset ? 1'b0 : md_busy_s;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized traffic for hazard_ctrl,
// checked against an array-based in-flight model. Honors HAZARD_MD_EN.
module tb_hazard_ctrl;

   localparam int NS       = 2;
   localparam int TW       = 2;
   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   logic            clk;
   logic            reset;
   logic [NS*5-1:0] d_src_addr;
   logic [NS-1:0]   d_src_used;
   logic [NS*TW-1:0] d_tuse;
   logic [4:0]      d_wa;
   logic [TW-1:0]   d_tnew;
   logic            d_md_start;
   logic            d_md_is_div;
   logic            d_md_use;
   logic            stall;
   logic [NS*2-1:0] fwd_sel;
   logic            md_busy;

   int n_checks = 0;
   int n_errors = 0;

   // model state: index 0 = E, 1 = M, 2 = W
   int sb_wa [3];
   int sb_tn [3];
   int md_left;
   bit md_pend;
   bit md_pend_div;
   bit exp_stall;

   hazard_ctrl #(
      .NUM_SRC (NS), .TW (TW), .MULT_LAT (MULT_LAT), .DIV_LAT (DIV_LAT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .D_src_addr  (d_src_addr),
      .D_src_used  (d_src_used),
      .D_tuse      (d_tuse),
      .D_wa        (d_wa),
      .D_tnew      (d_tnew),
      .D_md_start  (d_md_start),
      .D_md_is_div (d_md_is_div),
      .D_md_use    (d_md_use),
      .stall       (stall),
      .fwd_sel     (fwd_sel),
      .md_busy     (md_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_out(output bit st, output logic [NS*2-1:0] fs, output bit busy);
      st = 1'b0; fs = '0; busy = 1'b0;
      if (!reset) begin
         for (int i = 0; i < NS; i++) begin
            int a    = int'(d_src_addr[i*5 +: 5]);
            int tu   = int'(d_tuse[i*TW +: TW]);
            int near = -1;
            if (d_src_used[i] && a != 0) begin
               for (int s = 0; s < 3; s++) begin
                  if (sb_wa[s] == a) begin
                     if (tu < sb_tn[s]) st = 1'b1;
                     if (near < 0) near = s;
                  end
               end
            end
            if (near >= 0 && sb_tn[near] == 0) fs[i*2 +: 2] = 2'(near + 1);
         end
`ifdef HAZARD_MD_EN
         if ((d_md_use || d_md_start) && (md_left > 0 || md_pend)) st = 1'b1;
         busy = (md_left > 0);
`endif
      end
   endfunction

   task automatic sample();
      bit st; logic [NS*2-1:0] fs; bit busy;
      #1;
      model_out(st, fs, busy);
      exp_stall = st;
      chk("stall", 32'(stall), 32'(st));
      chk("fwd_sel", 32'(fwd_sel), 32'(fs));
      chk("md_busy", 32'(md_busy), 32'(busy));
   endtask

   task automatic advance();
      @(posedge clk);
      if (reset) begin
         for (int s = 0; s < 3; s++) begin sb_wa[s] = 0; sb_tn[s] = 0; end
         md_left = 0; md_pend = 1'b0; md_pend_div = 1'b0;
      end else begin
         sb_wa[2] = sb_wa[1]; sb_tn[2] = (sb_tn[1] > 0) ? sb_tn[1] - 1 : 0;
         sb_wa[1] = sb_wa[0]; sb_tn[1] = (sb_tn[0] > 0) ? sb_tn[0] - 1 : 0;
         sb_wa[0] = exp_stall ? 0 : int'(d_wa);
         sb_tn[0] = exp_stall ? 0 : int'(d_tnew);
`ifdef HAZARD_MD_EN
         if (md_left > 0) md_left--;
         if (md_pend) md_left = md_pend_div ? DIV_LAT : MULT_LAT;
         md_pend     = d_md_start && !exp_stall;
         md_pend_div = d_md_is_div;
`endif
      end
      @(negedge clk);
   endtask

   task automatic idle_in();
      d_src_addr = '0; d_src_used = '0; d_tuse = '0; d_wa = 5'd0; d_tnew = '0;
      d_md_start = 1'b0; d_md_is_div = 1'b0; d_md_use = 1'b0;
   endtask

   initial begin
      int n_st;
      int n_busy;
      for (int s = 0; s < 3; s++) begin sb_wa[s] = 0; sb_tn[s] = 0; end
      md_left = 0; md_pend = 1'b0; md_pend_div = 1'b0; exp_stall = 1'b0;
      idle_in();
      reset = 1'b1;
      @(negedge clk);
      d_src_used = 2'b11; d_src_addr = {5'd0, 5'd0};
      sample(); chk("rst_stall", 32'(stall), 32'd0); chk("rst_fwd", 32'(fwd_sel), 32'd0); advance();
      sample(); advance();
      reset = 1'b0; idle_in();
      sample(); advance();

      // load-use: E={8,2}, consumer tuse=1
      d_wa = 5'd8; d_tnew = 2'd2; sample(); advance();
      idle_in(); d_src_used = 2'b01; d_src_addr = {5'd0, 5'd8}; d_tuse = {2'd0, 2'd1};
      sample(); chk("lu_stall", 32'(stall), 32'd1); advance();
      sample(); chk("lu_release", 32'(stall), 32'd0); chk("lu_fwd_none", 32'(fwd_sel[1:0]), 32'd0); advance();
      sample(); chk("lu_fwd_w", 32'(fwd_sel[1:0]), 32'd3); advance();

      // ALU forward from E to source 1
      idle_in(); d_wa = 5'd3; d_tnew = 2'd0; sample(); advance();
      idle_in(); d_src_used = 2'b10; d_src_addr = {5'd3, 5'd0};
      sample(); chk("alu_stall", 32'(stall), 32'd0); chk("alu_fwd_e", 32'(fwd_sel[3:2]), 32'd1); advance();

      // nearest stage wins when E and M both hold r5
      idle_in(); d_wa = 5'd5; d_tnew = 2'd0; sample(); advance(); sample(); advance();
      idle_in(); d_src_used = 2'b01; d_src_addr = {5'd0, 5'd5};
      sample(); chk("near_fwd_e", 32'(fwd_sel[1:0]), 32'd1); advance();

      // register zero never hazards
      idle_in(); d_wa = 5'd0; d_tnew = 2'd2; sample(); advance();
      idle_in(); d_src_used = 2'b01;
      sample(); chk("r0_stall", 32'(stall), 32'd0); chk("r0_fwd", 32'(fwd_sel), 32'd0); advance();

`ifdef HAZARD_MD_EN
      // divide then mfhi: stalled until busy drops
      idle_in(); d_md_start = 1'b1; d_md_is_div = 1'b1; sample(); advance();
      idle_in(); d_md_use = 1'b1; n_st = 0; n_busy = 0;
      for (int k = 0; k < 30; k++) begin
         sample();
         if (stall) n_st++;
         if (md_busy) n_busy++;
         if (!stall) break;
         advance();
      end
      chk("div_stall_cycles", 32'(n_st), 32'd11);
      chk("div_busy_cycles", 32'(n_busy), 32'd10);
      advance();

      // reset with 4 mult cycles remaining
      idle_in(); d_wa = 5'd7; d_tnew = 2'd3; d_md_start = 1'b1; sample(); advance();
      idle_in(); sample(); chk("mult_busy0", 32'(md_busy), 32'd0); advance();
      sample(); chk("mult_busy1", 32'(md_busy), 32'd1); advance();
      reset = 1'b1; sample(); chk("abort_rst_busy", 32'(md_busy), 32'd0); advance();
      reset = 1'b0; d_md_use = 1'b1; d_src_used = 2'b01; d_src_addr = {5'd0, 5'd7}; d_tuse = {2'd0, 2'd0};
      sample(); chk("abort_busy", 32'(md_busy), 32'd0); chk("abort_stall", 32'(stall), 32'd0);
      chk("abort_fwd", 32'(fwd_sel), 32'd0); advance();
`else
      idle_in(); d_md_start = 1'b1; d_md_is_div = 1'b1; sample(); advance();
      idle_in(); d_md_use = 1'b1;
      sample(); chk("md_off_stall", 32'(stall), 32'd0); chk("md_off_busy", 32'(md_busy), 32'd0); advance();
      n_st = 0; n_busy = 0;
`endif

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         reset       = ($urandom_range(0, 59) == 0);
         d_src_addr  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         d_src_used  = 2'($urandom_range(0, 3));
         d_tuse      = 4'($urandom_range(0, 15));
         d_wa        = 5'($urandom_range(0, 3));
         d_tnew      = 2'($urandom_range(0, 3));
         d_md_start  = ($urandom_range(0, 9) == 0);
         d_md_is_div = 1'($urandom_range(0, 1));
         d_md_use    = ($urandom_range(0, 5) == 0);
         sample();
         advance();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
